// File: rtl/acorn128_decrypt_byte.sv
// ACORN-128 byte-wide decryption engine.
// Takes an already initialised 293-bit cipher state, then decrypts one
// ciphertext byte at a time, one bit per clock, LSB first. The updated
// state is always visible on state_out so the tag phase can pick it up.
module acorn128_decrypt_byte (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [292:0] state_in,
    input  logic         ca_in,
    input  logic         cb_in,
    input  logic         ct_valid,
    input  logic [7:0]   ct_byte,
    output logic         ct_ready,
    output logic         pt_valid,
    output logic [7:0]   pt_byte,
    input  logic         pt_ready,
    output logic [292:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [292:0] s_q;
    logic [292:0] s_lin;
    logic [292:0] s_step;
    logic [2:0]   cnt_q;
    logic [7:0]   ct_q;
    logic         ca_q;
    logic         cb_q;
    logic [7:0]   pt_q;
    logic         ks;
    logic         m_bit;
    logic         f_bit;
    logic         load_ok;
    logic         accept;

    // Load wins over a byte handshake; neither is possible while a byte is in flight
    assign load_ok = load && ((state_q == EMPTY) || (state_q == IDLE));
    assign accept  = ct_valid && (state_q == IDLE) && !load;

    // One cipher step: linear feedback in place, keystream, plaintext bit, shift-in
    always_comb begin
        s_lin      = s_q;
        s_lin[289] = s_q[289] ^ s_q[235] ^ s_q[230];
        s_lin[230] = s_q[230] ^ s_q[196] ^ s_q[193];
        s_lin[193] = s_q[193] ^ s_q[160] ^ s_q[154];
        s_lin[154] = s_q[154] ^ s_q[111] ^ s_q[107];
        s_lin[107] = s_q[107] ^ s_q[66]  ^ s_q[61];
        s_lin[61]  = s_q[61]  ^ s_q[23]  ^ s_q[0];

        ks = s_lin[12] ^ s_lin[154]
           ^ ((s_lin[235] & s_lin[61]) ^ (s_lin[235] & s_lin[193]) ^ (s_lin[61] & s_lin[193]))
           ^ ((s_lin[230] & s_lin[111]) ^ (~s_lin[230] & s_lin[66]));

        m_bit = ct_q[cnt_q] ^ ks;

        f_bit = s_lin[0] ^ ~s_lin[107]
              ^ ((s_lin[244] & s_lin[23]) ^ (s_lin[244] & s_lin[160]) ^ (s_lin[23] & s_lin[160]))
              ^ (ca_q & s_lin[196]) ^ (cb_q & ks);

        s_step = {f_bit ^ m_bit, s_lin[292:1]};
    end

    // Cipher state register: changes only on load or on a SHIFT step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
        end else if (load_ok) begin
            s_q <= state_in;
        end else if (state_q == SHIFT) begin
            s_q <= s_step;
        end
    end

    // Byte capture, bit counter and plaintext assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 3'd0;
            ct_q  <= 8'h00;
            ca_q  <= 1'b0;
            cb_q  <= 1'b0;
            pt_q  <= 8'h00;
        end else if (accept) begin
            cnt_q <= 3'd0;
            ct_q  <= ct_byte;
            ca_q  <= ca_in;
            cb_q  <= cb_in;
        end else if (state_q == SHIFT) begin
            pt_q[cnt_q] <= m_bit;
            cnt_q       <= cnt_q + 3'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load_ok) state_d = IDLE;
            IDLE: begin
                if (load_ok) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: if (cnt_q == 3'd7) state_d = HOLD;
            HOLD:  if (pt_ready) state_d = IDLE;
            default: state_d = EMPTY;
        endcase
    end

    // FSM outputs
    always_comb begin
        ct_ready = (state_q == IDLE);
        pt_valid = (state_q == HOLD);
        busy     = (state_q == SHIFT) || (state_q == HOLD);
    end

    assign pt_byte   = pt_q;
    assign state_out = s_q;

endmodule

// File: tb/tb_acorn128_decrypt_byte.sv
// Directed testbench for acorn128_decrypt_byte: reset behaviour, the
// all-zero-state vectors, back-pressure, reset abort, load priority and a
// 16-byte message encrypted by an independent ACORN-128 encryption model.
module tb_acorn128_decrypt_byte;

    logic         clk;
    logic         rst;
    logic         load;
    logic [292:0] state_in;
    logic         ca_in;
    logic         cb_in;
    logic         ct_valid;
    logic [7:0]   ct_byte;
    logic         ct_ready;
    logic         pt_valid;
    logic [7:0]   pt_byte;
    logic         pt_ready;
    logic [292:0] state_out;
    logic         busy;

    int errors = 0;
    int checks = 0;

    acorn128_decrypt_byte dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .state_in  (state_in),
        .ca_in     (ca_in),
        .cb_in     (cb_in),
        .ct_valid  (ct_valid),
        .ct_byte   (ct_byte),
        .ct_ready  (ct_ready),
        .pt_valid  (pt_valid),
        .pt_byte   (pt_byte),
        .pt_ready  (pt_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [292:0] obs, input logic [292:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, land 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doLoad(input logic [292:0] st);
        load     = 1'b1;
        state_in = st;
        tick();
        load     = 1'b0;
    endtask

    // Offer one ciphertext byte and return right after the acceptance edge
    task automatic applyStimulus(input logic [7:0] ct, input logic ca, input logic cb);
        int n;
        n        = 0;
        ct_byte  = ct;
        ca_in    = ca;
        cb_in    = cb;
        ct_valid = 1'b1;
        while (!ct_ready && n < 20) begin
            tick();
            n++;
        end
        if (!ct_ready) begin
            checkOutput("accept_timeout", 293'(ct_ready), 293'(1));
            ct_valid = 1'b0;
            return;
        end
        tick();
        ct_valid = 1'b0;
    endtask

    // Wait for pt_valid; the 8th step edge after acceptance must raise it
    task automatic waitPlain(input int already);
        int n;
        n = already;
        while (!pt_valid && n < 24) begin
            tick();
            n++;
        end
        checkOutput("latency", 293'(n), 293'(8));
    endtask

    task automatic takePlain(output logic [7:0] pt);
        pt       = pt_byte;
        pt_ready = 1'b1;
        tick();
        pt_ready = 1'b0;
    endtask

    // Independent ACORN-128 encryption step (plaintext bit in, ciphertext bit out)
    task automatic encStep(inout logic [292:0] s, input logic p, input logic ca,
                           input logic cb, output logic c);
        logic [292:0] t;
        logic k;
        logic f;
        t = s;
        t[289] = s[289] ^ s[235] ^ s[230];
        t[230] = s[230] ^ s[196] ^ s[193];
        t[193] = s[193] ^ s[160] ^ s[154];
        t[154] = s[154] ^ s[111] ^ s[107];
        t[107] = s[107] ^ s[66]  ^ s[61];
        t[61]  = s[61]  ^ s[23]  ^ s[0];
        k = t[12] ^ t[154] ^ ((t[235] & t[61]) | (t[235] & t[193]) | (t[61] & t[193]))
          ^ (t[230] ? t[111] : t[66]);
        c = p ^ k;
        f = t[0] ^ ~t[107] ^ ((t[244] & t[23]) | (t[244] & t[160]) | (t[23] & t[160]))
          ^ (ca & t[196]) ^ (cb & k);
        s = {f ^ p, t[292:1]};
    endtask

    function automatic logic [292:0] randState();
        logic [292:0] st;
        st = '0;
        for (int i = 0; i < 10; i++) begin
            st = (st << 32) | 293'($urandom);
        end
        return st;
    endfunction

    initial begin
        logic [292:0] zero_s;
        logic [292:0] r_s;
        logic [292:0] model_s;
        logic [292:0] held_s;
        logic [7:0]   pt;
        logic [7:0]   p;
        logic [7:0]   c;
        logic         cbit;
        logic         ca;
        logic         cb;
        int           pv_seen;

        zero_s   = '0;
        rst      = 1'b1;
        load     = 1'b0;
        state_in = '0;
        ca_in    = 1'b0;
        cb_in    = 1'b0;
        ct_valid = 1'b0;
        ct_byte  = 8'h00;
        pt_ready = 1'b0;
        void'($urandom(32'h1234_5678));

        // Reset state
        tick();
        tick();
        checkOutput("rst_state_out", state_out, zero_s);
        checkOutput("rst_pt_valid", 293'(pt_valid), 293'(0));
        checkOutput("rst_pt_byte", 293'(pt_byte), 293'(0));
        checkOutput("rst_ct_ready", 293'(ct_ready), 293'(0));
        checkOutput("rst_busy", 293'(busy), 293'(0));

        // Stays EMPTY after reset release; ct_valid ignored
        rst      = 1'b0;
        ct_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("empty_ct_ready", 293'(ct_ready), 293'(0));
            checkOutput("empty_busy", 293'(busy), 293'(0));
        end
        ct_valid = 1'b0;

        // All-zero state, ca=1 cb=0, ct=0x00
        doLoad(zero_s);
        checkOutput("idle_ct_ready", 293'(ct_ready), 293'(1));
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("shift_busy", 293'(busy), 293'(1));
        waitPlain(0);
        takePlain(pt);
        checkOutput("zero_pt", 293'(pt), 293'(8'h00));
        checkOutput("zero_state", state_out, {8'hFF, 285'd0});
        checkOutput("after_take_pt_valid", 293'(pt_valid), 293'(0));

        // All-zero state, ct=0xA5
        doLoad(zero_s);
        applyStimulus(8'hA5, 1'b1, 1'b0);
        waitPlain(0);
        takePlain(pt);
        checkOutput("a5_pt", 293'(pt), 293'(8'hA5));
        checkOutput("a5_state", state_out, {8'h5A, 285'd0});

        // Back-pressure: pt_ready low for 5 cycles
        doLoad(zero_s);
        applyStimulus(8'h3C, 1'b1, 1'b0);
        waitPlain(0);
        held_s = state_out;
        checkOutput("hold_state_val", held_s, {8'hC3, 285'd0});
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold_pt_valid", 293'(pt_valid), 293'(1));
            checkOutput("hold_pt_byte", 293'(pt_byte), 293'(8'h3C));
            checkOutput("hold_ct_ready", 293'(ct_ready), 293'(0));
            checkOutput("hold_state", state_out, {8'hC3, 285'd0});
        end
        pt_ready = 1'b1;
        tick();
        pt_ready = 1'b0;
        checkOutput("release_pt_valid", 293'(pt_valid), 293'(0));
        checkOutput("release_ct_ready", 293'(ct_ready), 293'(1));

        // Reset in the middle of a byte aborts it
        r_s = randState();
        doLoad(r_s);
        applyStimulus(8'h5E, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("abort_state_out", state_out, zero_s);
        checkOutput("abort_pt_valid", 293'(pt_valid), 293'(0));
        checkOutput("abort_pt_byte", 293'(pt_byte), 293'(0));
        checkOutput("abort_ct_ready", 293'(ct_ready), 293'(0));
        checkOutput("abort_busy", 293'(busy), 293'(0));
        tick();
        rst      = 1'b0;
        ct_valid = 1'b1;
        pv_seen  = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pt_valid || busy || ct_ready) pv_seen++;
        end
        ct_valid = 1'b0;
        checkOutput("abort_quiet", 293'(pv_seen), 293'(0));

        // Load beats a simultaneous ct handshake in IDLE
        doLoad(zero_s);
        r_s      = randState();
        load     = 1'b1;
        state_in = r_s;
        ct_valid = 1'b1;
        ct_byte  = 8'h77;
        tick();
        load     = 1'b0;
        ct_valid = 1'b0;
        checkOutput("ldpri_state", state_out, r_s);
        checkOutput("ldpri_busy", 293'(busy), 293'(0));
        checkOutput("ldpri_ct_ready", 293'(ct_ready), 293'(1));

        // Load and ct_byte changes during SHIFT are ignored
        doLoad(zero_s);
        applyStimulus(8'h00, 1'b1, 1'b0);
        tick();
        load     = 1'b1;
        state_in = r_s;
        ct_byte  = 8'hFF;
        tick();
        load     = 1'b0;
        waitPlain(2);
        takePlain(pt);
        checkOutput("ldshift_pt", 293'(pt), 293'(8'h00));
        checkOutput("ldshift_state", state_out, {8'hFF, 285'd0});

        // 16-byte message from a random state through the encryption model
        r_s     = randState();
        model_s = r_s;
        doLoad(r_s);
        for (int i = 0; i < 16; i++) begin
            p  = 8'($urandom);
            ca = 1'b1;
            cb = (i % 3 == 0);
            for (int b = 0; b < 8; b++) begin
                encStep(model_s, p[b], ca, cb, cbit);
                c[b] = cbit;
            end
            applyStimulus(c, ca, cb);
            waitPlain(0);
            takePlain(pt);
            checkOutput($sformatf("msg_pt%0d", i), 293'(pt), 293'(p));
        end
        checkOutput("msg_state", state_out, model_s);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
